// File: rtl/serial_adder_4bit.sv
// Bit-serial adder: one full-adder slice consumes the operands LSB-first, WIDTH+1 cycles from Start to Done.
// Define SERIAL_ADDER_OVERFLOW_EN to add the registered signed-overflow output.

module serial_adder_4bit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
`ifdef SERIAL_ADDER_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic             carry_q;
    logic [CNT_W-1:0] cnt;

    logic             capture;
    logic             shift;
    logic             last_bit;

    logic             ha0_sum;
    logic             ha0_carry;
    logic             ha1_sum;
    logic             ha1_carry;
    logic             bit_sum;
    logic             bit_carry;

    // Full-adder slice: two half adders chained, their carries merged by an OR.
    serial_adder_half_adder u_ha0 (
        .x     (a_sr[0]),
        .y     (b_sr[0]),
        .s     (ha0_sum),
        .c     (ha0_carry)
    );

    serial_adder_half_adder u_ha1 (
        .x     (ha0_sum),
        .y     (carry_q),
        .s     (ha1_sum),
        .c     (ha1_carry)
    );

    assign bit_sum   = ha1_sum;
    assign bit_carry = ha0_carry | ha1_carry;

    // The slice is processing the MSB, so this RUN edge completes the operation.
    assign last_bit  = (cnt == CNT_W'(WIDTH - 1));

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        shift      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    capture    = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                busy  = 1'b1;
                shift = 1'b1;
                if (last_bit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr      <= '0;
            b_sr      <= '0;
            carry_q   <= 1'b0;
            cnt       <= '0;
            sum       <= '0;
            carry_out <= 1'b0;
`ifdef SERIAL_ADDER_OVERFLOW_EN
            overflow  <= 1'b0;
`endif
        end else if (capture) begin
            a_sr    <= a;
            b_sr    <= b;
            carry_q <= carry_in;
            cnt     <= '0;
            sum     <= '0;
        end else if (shift) begin
            a_sr    <= a_sr >> 1;
            b_sr    <= b_sr >> 1;
            carry_q <= bit_carry;
            sum     <= {bit_sum, sum[WIDTH-1:1]};
            cnt     <= cnt + 1'b1;
            if (last_bit) begin
                carry_out <= bit_carry;
`ifdef SERIAL_ADDER_OVERFLOW_EN
                // Signed overflow: carry into the MSB differs from carry out of it.
                overflow  <= carry_q ^ bit_carry;
`endif
            end
        end
    end

endmodule

module serial_adder_half_adder (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);

    assign s = x ^ y;
    assign c = x & y;

endmodule

// File: tb/tb_serial_adder_4bit.sv
// Scoreboard bench for serial_adder_4bit: driver pushes model results at capture, monitor pops on Done.
// Overflow checks are compiled in when SERIAL_ADDER_OVERFLOW_EN is defined.

module tb_serial_adder_4bit;

    localparam int W = 4;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         carry_in;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         carry_out;
`ifdef SERIAL_ADDER_OVERFLOW_EN
    logic         overflow;
`endif

    int   checks;
    int   failures;
    int   cyc;
    exp_t exp_q[$];
    int   done_cycles[$];

    serial_adder_4bit #(
        .WIDTH     (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a         (a),
        .b         (b),
        .carry_in  (carry_in),
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .carry_out (carry_out)
`ifdef SERIAL_ADDER_OVERFLOW_EN
        ,
        .overflow  (overflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Reference: plain integer arithmetic, unsigned for sum/carry and signed range test for overflow.
    function automatic exp_t ref_model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
        exp_t r;
        int   total;
        int   sx;
        int   sy;
        int   ssum;
        total  = int'(x) + int'(y) + int'(ci);
        r.sum  = W'(total % (1 << W));
        r.cout = ((total >> W) & 1) == 1;
        sx = int'(x);
        sy = int'(y);
        if (sx >= 2 ** (W - 1)) sx -= 2 ** W;
        if (sy >= 2 ** (W - 1)) sy -= 2 ** W;
        ssum  = sx + sy + int'(ci);
        r.ovf = (ssum > 2 ** (W - 1) - 1) || (ssum < -(2 ** (W - 1)));
        return r;
    endfunction

    // Monitor: every Done pulse consumes exactly one expected result.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_cycles.push_back(cyc);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: got done=1 with no pending result (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("result_sum", sum, e.sum);
                check("result_carry_out", carry_out, e.cout);
`ifdef SERIAL_ADDER_OVERFLOW_EN
                check("result_overflow", overflow, e.ovf);
`endif
            end
        end
    end

    task automatic check_cleared(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_sum"}, sum, 0);
        check({tag, "_carry_out"}, carry_out, 0);
`ifdef SERIAL_ADDER_OVERFLOW_EN
        check({tag, "_overflow"}, overflow, 0);
`endif
    endtask

    // One operation with cycle-exact Busy/Done checks; disturb re-pulses Start and scrambles operands mid-run.
    task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv, input bit disturb);
        exp_t e;
        int   busy_cycles;
        e = ref_model(av, bv, cv);
        @(negedge clk);
        a        = av;
        b        = bv;
        carry_in = cv;
        start    = 1'b1;
        @(posedge clk);
        exp_q.push_back(e);
        #1;
        start = 1'b0;
        busy_cycles = 0;
        check("capture_busy", busy, 1);
        check("capture_sum_cleared", sum, 0);
        if (busy === 1'b1) busy_cycles++;
        if (disturb) begin
            a        = ~av;
            b        = W'($urandom);
            carry_in = ~cv;
        end
        for (int k = 1; k <= W + 2; k++) begin
            start = disturb && (k == 2 || k == 5);
            @(posedge clk);
            #1;
            start = 1'b0;
            if (busy === 1'b1) busy_cycles++;
            if (k < W) begin
                check("run_busy", busy, 1);
                check("run_done", done, 0);
            end else if (k == W) begin
                check("latency_done", done, 1);
                check("latency_busy", busy, 0);
            end else begin
                check("post_done", done, 0);
                check("post_busy", busy, 0);
            end
        end
        check("busy_cycle_count", busy_cycles, W);
        check("hold_sum", sum, e.sum);
        check("hold_carry_out", carry_out, e.cout);
    endtask

    task automatic reset_abort();
        @(negedge clk);
        a        = W'($urandom);
        b        = W'($urandom);
        carry_in = 1'b1;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_cleared("abort_async");
        @(posedge clk);
        #1;
        check("abort_held_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (W + 3) @(posedge clk);
        #1;
        check("abort_idle_busy", busy, 0);
        check("abort_idle_sum", sum, 0);
    endtask

    task automatic back_to_back();
        logic [W-1:0] av[3];
        logic [W-1:0] bv[3];
        logic         cv[3];
        int           base;
        for (int i = 0; i < 3; i++) begin
            av[i] = W'($urandom);
            bv[i] = W'($urandom);
            cv[i] = 1'($urandom);
        end
        base = done_cycles.size();
        @(negedge clk);
        a        = av[0];
        b        = bv[0];
        carry_in = cv[0];
        start    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            exp_q.push_back(ref_model(av[i], bv[i], cv[i]));
            #1;
            check("b2b_capture_busy", busy, 1);
            if (i < 2) begin
                a        = av[i+1];
                b        = bv[i+1];
                carry_in = cv[i+1];
                repeat (W + 1) @(posedge clk);
            end else begin
                start = 1'b0;
            end
        end
        repeat (W + 3) @(posedge clk);
        #1;
        check("b2b_done_count", done_cycles.size() - base, 3);
        if (done_cycles.size() - base >= 3) begin
            for (int j = 1; j < 3; j++) begin
                check("b2b_spacing", done_cycles[base+j] - done_cycles[base+j-1], W + 2);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks   = 0;
        failures = 0;
        cyc      = 0;
        rst      = 1'b1;
        start    = 1'b0;
        a        = '0;
        b        = '0;
        carry_in = 1'b0;
        #3;
        check_cleared("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        do_op(4'b0101, 4'b0011, 1'b0, 1'b0);
        do_op(4'b1111, 4'b0001, 1'b0, 1'b0);
        do_op(4'b1111, 4'b1111, 1'b1, 1'b0);
        do_op(4'b0111, 4'b0001, 1'b0, 1'b0);
        do_op(4'b1000, 4'b1111, 1'b0, 1'b0);
        do_op(4'b0011, 4'b0010, 1'b0, 1'b0);
        do_op(4'b0110, 4'b0101, 1'b1, 1'b1);

        reset_abort();
        do_op(4'b1001, 4'b0110, 1'b1, 1'b0);

        back_to_back();

        for (int i = 0; i < 20; i++) begin
            do_op(W'($urandom), W'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0));
        end

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
